// File: rtl/sorter_arbiter.sv
// Round-robin front end sharing one multicycle nth_smallest sorter among
// NUM_REQ requesters; a watchdog drops jobs whose result never returns.
module sorter_arbiter #(
    parameter int MAX_NUM_SIZE   = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic [NUM_REQ-1:0]                          req_valid_in,
    input  logic [NUM_REQ-1:0][3:0][MAX_NUM_SIZE-1:0]   req_numbers_in,
    input  logic [NUM_REQ-1:0][1:0]                     req_index_in,
    output logic [NUM_REQ-1:0]                          req_ready_out,
    output logic [NUM_REQ-1:0]                          resp_valid_out,
    output logic [MAX_NUM_SIZE-1:0]                     resp_nth_min_out,
    output logic [1:0]                                  resp_num_of_mins_out,
    output logic [3:0][MAX_NUM_SIZE-1:0]                resp_sorted_out,
    output logic                                        timeout_out,
    output logic                                        sort_valid_out,
    output logic [3:0][MAX_NUM_SIZE-1:0]                sort_numbers_out,
    output logic [1:0]                                  sort_index_out,
    input  logic                                        sort_busy_in,
    input  logic                                        sort_valid_in,
    input  logic [MAX_NUM_SIZE-1:0]                     sort_nth_min_in,
    input  logic [1:0]                                  sort_num_of_mins_in,
    input  logic [3:0][MAX_NUM_SIZE-1:0]                sort_sorted_in,
    output logic [1:0]                                  state_out
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t                          state;
    logic [ID_W-1:0]                 ptr;
    logic [ID_W-1:0]                 id_q;
    logic [3:0][MAX_NUM_SIZE-1:0]    num_q;
    logic [1:0]                      idx_q;
    logic [WD_W-1:0]                 wdog;

    logic                            grant_found;
    logic [ID_W-1:0]                 grant_id;
    logic [ID_W-1:0]                 cand;
    logic [ID_W-1:0]                 ptr_next;

    // Handshake: a requester holds req_valid_in and its operands until it sees
    // its req_ready_out pulse; operands are captured on the edge that raises
    // that pulse, so the requester may change or drop them from then on.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid_in[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign ptr_next = ID_W'((int'(grant_id) + 1) % NUM_REQ);

    // Latched operands stay on the sorter bus for the whole job.
    assign sort_numbers_out = num_q;
    assign sort_index_out   = idx_q;
    assign state_out        = state;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                <= IDLE;
            ptr                  <= '0;
            id_q                 <= '0;
            num_q                <= '0;
            idx_q                <= '0;
            wdog                 <= '0;
            req_ready_out        <= '0;
            resp_valid_out       <= '0;
            resp_nth_min_out     <= '0;
            resp_num_of_mins_out <= '0;
            resp_sorted_out      <= '0;
            timeout_out          <= 1'b0;
            sort_valid_out       <= 1'b0;
        end else begin
            req_ready_out  <= '0;
            resp_valid_out <= '0;
            timeout_out    <= 1'b0;
            sort_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        req_ready_out[grant_id] <= 1'b1;
                        num_q                   <= req_numbers_in[grant_id];
                        idx_q                   <= req_index_in[grant_id];
                        id_q                    <= grant_id;
                        ptr                     <= ptr_next;
                        state                   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!sort_busy_in) begin
                        sort_valid_out <= 1'b1;
                        wdog           <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // Result pulse is raised here so it lands one cycle after the sorter's valid.
                    if (sort_valid_in) begin
                        resp_valid_out[id_q] <= 1'b1;
                        resp_nth_min_out     <= sort_nth_min_in;
                        resp_num_of_mins_out <= sort_num_of_mins_in;
                        resp_sorted_out      <= sort_sorted_in;
                        state                <= DELIVER;
                    end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_out <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DELIVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_arbiter.sv
// Directed bench for sorter_arbiter with a behavioural 5-cycle sorter model.
module tb_sorter_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int LAT = 5;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                      rst_in;
    logic [N-1:0]              req_valid_in;
    logic [N-1:0][3:0][W-1:0]  req_numbers_in;
    logic [N-1:0][1:0]         req_index_in;
    logic [N-1:0]              req_ready_out;
    logic [N-1:0]              resp_valid_out;
    logic [W-1:0]              resp_nth_min_out;
    logic [1:0]                resp_num_of_mins_out;
    logic [3:0][W-1:0]         resp_sorted_out;
    logic                      timeout_out;
    logic                      sort_valid_out;
    logic [3:0][W-1:0]         sort_numbers_out;
    logic [1:0]                sort_index_out;
    logic                      sort_busy_in;
    logic                      sort_valid_in;
    logic [W-1:0]              sort_nth_min_in = '0;
    logic [1:0]                sort_num_of_mins_in = '0;
    logic [3:0][W-1:0]         sort_sorted_in = '0;
    logic [1:0]                state_out;

    logic busy_force  = 1'b0;
    logic busy_m      = 1'b0;
    logic model_valid = 1'b0;
    logic stray_valid = 1'b0;
    logic sort_en     = 1'b1;
    int   cnt         = 0;

    assign sort_busy_in  = busy_force | busy_m;
    assign sort_valid_in = model_valid | stray_valid;

    sorter_arbiter #(.MAX_NUM_SIZE(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_numbers_in(req_numbers_in), .req_index_in(req_index_in),
        .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
        .resp_nth_min_out(resp_nth_min_out), .resp_num_of_mins_out(resp_num_of_mins_out),
        .resp_sorted_out(resp_sorted_out), .timeout_out(timeout_out),
        .sort_valid_out(sort_valid_out), .sort_numbers_out(sort_numbers_out),
        .sort_index_out(sort_index_out), .sort_busy_in(sort_busy_in), .sort_valid_in(sort_valid_in),
        .sort_nth_min_in(sort_nth_min_in), .sort_num_of_mins_in(sort_num_of_mins_in),
        .sort_sorted_in(sort_sorted_in), .state_out(state_out)
    );

    // Sorter model: samples operands when its result becomes due.
    always @(posedge clk_in) begin
        logic [3:0][W-1:0] t;
        logic [W-1:0]      x;
        int                c;
        #1;
        model_valid = 1'b0;
        if (rst_in) begin
            cnt    = 0;
            busy_m = 1'b0;
        end else if (cnt != 0) begin
            cnt--;
            if (cnt == 0) begin
                busy_m = 1'b0;
                if (sort_en) begin
                    t = sort_numbers_out;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3 - i; j++)
                            if (t[j] > t[j+1]) begin
                                x = t[j]; t[j] = t[j+1]; t[j+1] = x;
                            end
                    sort_sorted_in  = t;
                    sort_nth_min_in = t[sort_index_out];
                    c = 0;
                    for (int i = 0; i < 4; i++) if (t[i] == sort_nth_min_in) c++;
                    sort_num_of_mins_in = 2'(c);
                    model_valid = 1'b1;
                end
            end
        end else if (sort_valid_out) begin
            cnt    = LAT;
            busy_m = 1'b1;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [3:0][W-1:0] pack4(input logic [W-1:0] a, b, c, d);
        logic [3:0][W-1:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    task automatic wait_grant(output logic [N-1:0] g);
        bit found;
        found = 1'b0;
        g = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_in);
            if (req_ready_out != '0) begin
                g = req_ready_out;
                found = 1'b1;
            end
        end
    endtask

    task automatic finish_job(input string tag, input logic [N-1:0] exp_id, input logic [W-1:0] exp_nth,
                              input logic [1:0] exp_cnt, input logic [3:0][W-1:0] exp_sorted);
        bit seen;
        bit ovl;
        seen = 1'b0;
        ovl  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            if (req_ready_out != '0) ovl = 1'b1;
            if (sort_valid_in) seen = 1'b1;
        end
        check({tag, "_sorter_done"}, 128'(seen), 128'(1));
        @(negedge clk_in);
        check({tag, "_resp_id"}, 128'(resp_valid_out), 128'(exp_id));
        check({tag, "_nth_min"}, 128'(resp_nth_min_out), 128'(exp_nth));
        check({tag, "_num_mins"}, 128'(resp_num_of_mins_out), 128'(exp_cnt));
        check({tag, "_sorted"}, resp_sorted_out, exp_sorted);
        check({tag, "_no_overlap"}, 128'(ovl), 128'(0));
    endtask

    logic [W-1:0]      exp_nth[N];
    logic [1:0]        exp_cnt[N];
    logic [3:0][W-1:0] exp_sorted[N];
    logic [1:0]        exp_q[$];

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] onehot;
        logic [1:0]   id;
        bit           early;
        bit           resp_seen;

        rst_in = 1'b1;
        req_valid_in = '0;
        req_numbers_in = '0;
        req_index_in = '0;
        req_numbers_in[0] = pack4(4, 1, 3, 2); req_index_in[0] = 2'd0;
        req_numbers_in[1] = pack4(5, 5, 8, 6); req_index_in[1] = 2'd1;
        req_numbers_in[2] = pack4(9, 3, 7, 3); req_index_in[2] = 2'd2;
        req_numbers_in[3] = pack4(2, 2, 2, 1); req_index_in[3] = 2'd3;
        exp_nth[0] = 1; exp_cnt[0] = 1; exp_sorted[0] = pack4(1, 2, 3, 4);
        exp_nth[1] = 5; exp_cnt[1] = 2; exp_sorted[1] = pack4(5, 5, 6, 8);
        exp_nth[2] = 7; exp_cnt[2] = 1; exp_sorted[2] = pack4(3, 3, 7, 9);
        exp_nth[3] = 2; exp_cnt[3] = 3; exp_sorted[3] = pack4(1, 2, 2, 2);

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_ready", 128'(req_ready_out), 128'(0));
        check("rst_resp", 128'(resp_valid_out), 128'(0));
        check("rst_timeout", 128'(timeout_out), 128'(0));
        check("rst_sort_valid", 128'(sort_valid_out), 128'(0));
        check("rst_sort_numbers", sort_numbers_out, 128'(0));
        check("rst_sort_index", 128'(sort_index_out), 128'(0));
        check("rst_resp_sorted", resp_sorted_out, 128'(0));
        check("rst_state", 128'(state_out), 128'(0));

        // Contention: grants 0,1,2,3,0
        rst_in = 1'b0;
        req_valid_in = 4'b1111;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int j = 0; j < 5; j++) begin
            wait_grant(g);
            id = exp_q.pop_front();
            onehot = '0;
            onehot[id] = 1'b1;
            check("cont_grant", 128'(g), 128'(onehot));
            if (j == 4) req_valid_in = '0;
            finish_job("cont", onehot, exp_nth[id], exp_cnt[id], exp_sorted[id]);
        end

        // Single job from requester 2
        req_index_in[2] = 2'd0;
        req_valid_in = 4'b0100;
        wait_grant(g);
        check("single_grant", 128'(g), 128'(4'b0100));
        req_valid_in = '0;
        finish_job("single", 4'b0100, 3, 2'd2, pack4(3, 3, 7, 9));
        @(negedge clk_in);
        check("single_resp_pulse", 128'(resp_valid_out), 128'(0));
        check("single_idle", 128'(state_out), 128'(0));

        // Operand stability: requester 1 changes its operands after the grant
        req_numbers_in[1] = pack4(8, 6, 7, 5);
        req_index_in[1] = 2'd1;
        req_valid_in = 4'b0010;
        wait_grant(g);
        check("stable_grant", 128'(g), 128'(4'b0010));
        req_valid_in = '0;
        req_numbers_in[1] = pack4(1, 1, 1, 1);
        req_index_in[1] = 2'd3;
        @(negedge clk_in);
        check("stable_launch", 128'(sort_valid_out), 128'(1));
        check("stable_numbers", sort_numbers_out, pack4(8, 6, 7, 5));
        check("stable_index", 128'(sort_index_out), 128'(1));
        finish_job("stable", 4'b0010, 6, 2'd1, pack4(5, 6, 7, 8));

        // Busy hold-off in LAUNCH
        busy_force = 1'b1;
        req_valid_in = 4'b0001;
        wait_grant(g);
        check("busy_grant", 128'(g), 128'(4'b0001));
        req_valid_in = '0;
        for (int k = 0; k < 4; k++) begin
            check("busy_hold", 128'(sort_valid_out), 128'(0));
            if (k < 3) @(negedge clk_in);
        end
        busy_force = 1'b0;
        @(negedge clk_in);
        check("busy_launch", 128'(sort_valid_out), 128'(1));
        @(negedge clk_in);
        check("busy_launch_pulse", 128'(sort_valid_out), 128'(0));
        finish_job("busy", 4'b0001, 1, 2'd1, pack4(1, 2, 3, 4));

        // Timeout: sorter never answers
        sort_en = 1'b0;
        req_valid_in = 4'b1000;
        wait_grant(g);
        check("to_grant", 128'(g), 128'(4'b1000));
        req_valid_in = '0;
        @(negedge clk_in);
        check("to_launch", 128'(sort_valid_out), 128'(1));
        early = 1'b0;
        resp_seen = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk_in);
            if (resp_valid_out != '0) resp_seen = 1'b1;
            if (k < TO && timeout_out) early = 1'b1;
        end
        check("to_pulse", 128'(timeout_out), 128'(1));
        check("to_not_early", 128'(early), 128'(0));
        check("to_no_resp", 128'(resp_seen), 128'(0));
        @(negedge clk_in);
        check("to_pulse_end", 128'(timeout_out), 128'(0));
        check("to_idle", 128'(state_out), 128'(0));
        stray_valid = 1'b1;
        @(negedge clk_in);
        stray_valid = 1'b0;
        @(negedge clk_in);
        check("stray_no_resp", 128'(resp_valid_out), 128'(0));
        check("stray_idle", 128'(state_out), 128'(0));
        sort_en = 1'b1;

        // Reset in the middle of WAIT
        req_valid_in = 4'b0100;
        wait_grant(g);
        check("mrst_grant", 128'(g), 128'(4'b0100));
        req_valid_in = '0;
        @(negedge clk_in);
        check("mrst_launch", 128'(sort_valid_out), 128'(1));
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("mrst_state", 128'(state_out), 128'(0));
        check("mrst_resp_nth", 128'(resp_nth_min_out), 128'(0));
        check("mrst_resp_cnt", 128'(resp_num_of_mins_out), 128'(0));
        check("mrst_resp_sorted", resp_sorted_out, 128'(0));
        check("mrst_sort_numbers", sort_numbers_out, 128'(0));
        check("mrst_outs", 128'({req_ready_out, resp_valid_out, timeout_out, sort_valid_out, sort_index_out}),
              128'(0));
        rst_in = 1'b0;
        early = 1'b0;
        for (int k = 0; k < TO + 4; k++) begin
            @(negedge clk_in);
            if (resp_valid_out != '0 || timeout_out) early = 1'b1;
        end
        check("mrst_quiet", 128'(early), 128'(0));

        // Pointer back at 0: requesters 1 and 3 compete, 1 wins
        req_numbers_in[1] = pack4(8, 6, 7, 5);
        req_index_in[1] = 2'd3;
        req_valid_in = 4'b1010;
        wait_grant(g);
        check("post_rst_grant", 128'(g), 128'(4'b0010));
        req_valid_in = '0;
        finish_job("post_rst", 4'b0010, 8, 2'd1, pack4(5, 6, 7, 8));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
